// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: load/store size selects
// (as driven by the core's control logic) and the responder FSM states.
package dmem_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// load lane extraction with sign or zero extension, and alignment/select checks.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  load_sel_i,
    input  logic [1:0]  store_sel_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlanes_o,
    output logic [31:0] ldata_o,
    output logic        align_err_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword_i[{lane_i, 3'b000} +: 8];
    assign rhalf = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be_o        = 4'b0000;
        wlanes_o    = 32'h0;
        ldata_o     = 32'h0;
        align_err_o = 1'b0;
        if (we_i) begin
            // Write data is replicated across lanes; the byte enables pick the target.
            unique case (store_sel_i)
                ST_SB: begin
                    be_o     = 4'b0001 << lane_i;
                    wlanes_o = {4{wdata_i[7:0]}};
                end
                ST_SH: begin
                    be_o        = lane_i[1] ? 4'b1100 : 4'b0011;
                    wlanes_o    = {2{wdata_i[15:0]}};
                    align_err_o = lane_i[0];
                end
                ST_SW: begin
                    be_o        = 4'b1111;
                    wlanes_o    = wdata_i;
                    align_err_o = |lane_i;
                end
                default: align_err_o = 1'b1;
            endcase
        end else begin
            unique case (load_sel_i)
                LD_LB:  ldata_o = {{24{rbyte[7]}}, rbyte};
                LD_LBU: ldata_o = {24'h0, rbyte};
                LD_LH: begin
                    ldata_o     = {{16{rhalf[15]}}, rhalf};
                    align_err_o = lane_i[0];
                end
                LD_LHU: begin
                    ldata_o     = {16'h0, rhalf};
                    align_err_o = lane_i[0];
                end
                LD_LW: begin
                    ldata_o     = rword_i;
                    align_err_o = |lane_i;
                end
                default: align_err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: accepts one load/store at a time, waits a
// fixed number of cycles, commits to the RAM and holds the response until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_load_sel,
    input  logic [1:0]  req_store_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  lsel_q, lsel_d;
    logic [1:0]  ssel_q, ssel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  commit;
    logic                  in_idle;
    logic                  f_we;
    logic [31:0]           f_addr;
    logic [31:0]           f_wdata;
    logic [2:0]            f_lsel;
    logic [1:0]            f_ssel;
    logic [32:0]           diff;
    logic                  in_win;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic [31:0]           ldata;
    logic                  align_err;
    logic                  acc_err;

    // With zero wait states the commit happens on the accepting edge, so the
    // access fields come straight from the request port while in IDLE.
    assign in_idle = (state_q == IDLE);
    assign f_we    = in_idle ? req_we        : we_q;
    assign f_addr  = in_idle ? req_addr      : addr_q;
    assign f_wdata = in_idle ? req_wdata     : wdata_q;
    assign f_lsel  = in_idle ? req_load_sel  : lsel_q;
    assign f_ssel  = in_idle ? req_store_sel : ssel_q;

    // A borrow or any set bit above the window shows up in the upper bits.
    assign diff    = {1'b0, f_addr} - {1'b0, BASE_ADDR};
    assign in_win  = (diff[32:ADDR_WIDTH+2] == '0);
    assign idx     = diff[ADDR_WIDTH+1:2];
    assign acc_err = align_err | ~in_win;

    dmem_lane_align u_align (
        .we_i        (f_we),
        .lane_i      (diff[1:0]),
        .wdata_i     (f_wdata),
        .load_sel_i  (f_lsel),
        .store_sel_i (f_ssel),
        .rword_i     (mem[idx]),
        .be_o        (be),
        .wlanes_o    (wlanes),
        .ldata_o     (ldata),
        .align_err_o (align_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lsel_d  = lsel_q;
        ssel_d  = ssel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    lsel_d  = req_load_sel;
                    ssel_d  = req_store_sel;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rdata_d = (f_we || acc_err) ? 32'h0 : ldata;
            err_d   = acc_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            lsel_q  <= 3'b000;
            ssel_q  <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lsel_q  <= lsel_d;
            ssel_q  <= ssel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && f_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus randomized accesses checked
// against a byte-array memory model; a second instance covers wait=3 and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a       [2];
    logic        req_valid_a [2];
    logic        req_ready_a [2];
    logic        req_we_a    [2];
    logic [31:0] req_addr_a  [2];
    logic [31:0] req_wdata_a [2];
    logic [2:0]  req_lsel_a  [2];
    logic [1:0]  req_ssel_a  [2];
    logic        rsp_valid_a [2];
    logic        rsp_ready_a [2];
    logic [31:0] rsp_rdata_a [2];
    logic        rsp_err_a   [2];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mm [4096];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst_a[0]),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_we(req_we_a[0]),
        .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .req_load_sel(req_lsel_a[0]), .req_store_sel(req_ssel_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]),
        .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_4000)) u_dut3 (
        .clk(clk), .rst(rst_a[1]),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_we(req_we_a[1]),
        .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .req_load_sel(req_lsel_a[1]), .req_store_sel(req_ssel_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]),
        .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain byte-addressed memory, sizes and rules from the access type.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] lsel, input logic [1:0] ssel,
                         output logic [31:0] exp_rd, output logic exp_err);
        int  size;
        bit  bad;
        logic [31:0] v;
        bad  = 1'b0;
        size = 1;
        if (we) begin
            if (ssel == 2'd3) bad = 1'b1;
            else size = 1 << ssel;
        end else begin
            case (lsel)
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                default:    bad  = 1'b1;
            endcase
        end
        if (addr % size != 0) bad = 1'b1;
        if (addr >= 32'd4096) bad = 1'b1;
        exp_rd  = 32'h0;
        exp_err = bad;
        if (!bad) begin
            if (we) begin
                for (int i = 0; i < size; i++) mm[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(mm[addr + i]) << (8*i));
                if (size < 4 && !lsel[2] && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                exp_rd = v;
            end
        end
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] lsel,
                        input logic [1:0] ssel, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        req_we_a[k]    = we;
        req_addr_a[k]  = addr;
        req_wdata_a[k] = wdata;
        req_lsel_a[k]  = lsel;
        req_ssel_a[k]  = ssel;
        req_valid_a[k] = 1'b1;
        guard = 0;
        while (!req_ready_a[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_bound", 32'(guard < 50), 32'd1);
        @(negedge clk);
        req_valid_a[k] = 1'b0;
        lat = 1;
        while (!rsp_valid_a[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata_a[k];
        er = rsp_err_a[k];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid_a[k]), 32'd1);
            chk("hold_rdata", rsp_rdata_a[k], rd);
            chk("hold_err", 32'(rsp_err_a[k]), 32'(er));
            chk("hold_req_ready", 32'(req_ready_a[k]), 32'd0);
        end
        rsp_ready_a[k] = 1'b1;
        @(negedge clk);
        rsp_ready_a[k] = 1'b0;
        chk("rsp_drop", 32'(rsp_valid_a[k]), 32'd0);
    endtask

    task automatic run0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] lsel, input logic [1:0] ssel, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        model(we, addr, wdata, lsel, ssel, exp_rd, exp_err);
        xact(0, we, addr, wdata, lsel, ssel, hold, rd, er, lat);
        chk("latency", 32'(lat), 32'd2);
        chk("rdata", rd, exp_rd);
        chk("err", 32'(er), 32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, guard;
        logic [2:0]  legal [5];
        logic [31:0] a;
        int          r;
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        for (int k = 0; k < 2; k++) begin
            rst_a[k] = 1'b1; req_valid_a[k] = 1'b0; req_we_a[k] = 1'b0;
            req_addr_a[k] = '0; req_wdata_a[k] = '0; req_lsel_a[k] = '0;
            req_ssel_a[k] = '0; rsp_ready_a[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_a[0]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_a[0]), 32'd0);
        chk("rst_rdata", rsp_rdata_a[0], 32'h0);
        chk("rst_err", 32'(rsp_err_a[0]), 32'd0);
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;

        run0(1, 32'h10, 32'hDEADBEEF, 3'd0, 2'd2, 0, rd, er);
        run0(0, 32'h10, 32'h0, 3'd2, 2'd0, 0, rd, er);
        chk("lw_10_a", rd, 32'hDEADBEEF);
        run0(1, 32'h11, 32'h0000_00AA, 3'd0, 2'd0, 0, rd, er);
        run0(0, 32'h10, 32'h0, 3'd2, 2'd0, 0, rd, er);
        chk("lw_10_b", rd, 32'hDEADAAEF);
        run0(0, 32'h11, 32'h0, 3'd0, 2'd0, 0, rd, er);
        chk("lb_11", rd, 32'hFFFFFFAA);
        run0(0, 32'h11, 32'h0, 3'd4, 2'd0, 0, rd, er);
        chk("lbu_11", rd, 32'h0000_00AA);
        run0(1, 32'h12, 32'h0000_8001, 3'd0, 2'd1, 0, rd, er);
        run0(0, 32'h12, 32'h0, 3'd1, 2'd0, 0, rd, er);
        chk("lh_12", rd, 32'hFFFF8001);
        run0(0, 32'h12, 32'h0, 3'd5, 2'd0, 0, rd, er);
        chk("lhu_12", rd, 32'h0000_8001);
        run0(0, 32'h10, 32'h0, 3'd2, 2'd0, 0, rd, er);
        chk("lw_10_c", rd, 32'h8001AAEF);

        run0(0, 32'h13, 32'h0, 3'd2, 2'd0, 1, rd, er);
        chk("err_lw_13", {rd[30:0], er}, 32'd1);
        run0(1, 32'h11, 32'h5555, 3'd0, 2'd1, 0, rd, er);
        chk("err_sh_11", {rd[30:0], er}, 32'd1);
        run0(0, 32'h10, 32'h0, 3'd3, 2'd0, 0, rd, er);
        chk("err_lsel_3", {rd[30:0], er}, 32'd1);
        run0(0, 32'h1000, 32'h0, 3'd2, 2'd0, 0, rd, er);
        chk("err_oow", {rd[30:0], er}, 32'd1);
        run0(0, 32'h10, 32'h0, 3'd2, 2'd0, 0, rd, er);
        chk("lw_10_after_err", rd, 32'h8001AAEF);

        // Back-pressure with a new request already waiting.
        @(negedge clk);
        req_we_a[0] = 1'b0; req_addr_a[0] = 32'h10; req_lsel_a[0] = 3'd2; req_valid_a[0] = 1'b1;
        @(negedge clk);
        req_addr_a[0] = 32'h11; req_lsel_a[0] = 3'd0;
        chk("bp_wait_ready", 32'(req_ready_a[0]), 32'd0);
        guard = 0;
        while (!rsp_valid_a[0] && guard < 50) begin @(negedge clk); guard++; end
        rd = rsp_rdata_a[0];
        chk("bp_rdata", rd, 32'h8001AAEF);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid_a[0]), 32'd1);
            chk("bp_stable", rsp_rdata_a[0], rd);
            chk("bp_req_ready", 32'(req_ready_a[0]), 32'd0);
        end
        rsp_ready_a[0] = 1'b1;
        @(negedge clk);
        rsp_ready_a[0] = 1'b0;
        chk("bp_idle_valid", 32'(rsp_valid_a[0]), 32'd0);
        chk("bp_idle_ready", 32'(req_ready_a[0]), 32'd1);
        @(negedge clk);
        chk("bp_accepted", 32'(req_ready_a[0]), 32'd0);
        req_valid_a[0] = 1'b0;
        guard = 0;
        while (!rsp_valid_a[0] && guard < 50) begin @(negedge clk); guard++; end
        chk("bp_second_rdata", rsp_rdata_a[0], 32'hFFFFFFAA);
        rsp_ready_a[0] = 1'b1;
        @(negedge clk);
        rsp_ready_a[0] = 1'b0;

        // Wait=3 instance, windowed at 0x4000.
        xact(1, 1, 32'h4020, 32'h0, 3'd0, 2'd2, 0, rd, er, lat);
        chk("w3_latency", 32'(lat), 32'd4);
        chk("w3_sw_err", 32'(er), 32'd0);
        xact(1, 0, 32'h20, 32'h0, 3'd2, 2'd0, 0, rd, er, lat);
        chk("w3_below_base", {rd[30:0], er}, 32'd1);
        @(negedge clk);
        req_we_a[1] = 1'b1; req_addr_a[1] = 32'h4020; req_wdata_a[1] = 32'h12345678;
        req_ssel_a[1] = 2'd2; req_valid_a[1] = 1'b1;
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        chk("w3_in_wait", 32'(req_ready_a[1]), 32'd0);
        @(negedge clk);
        rst_a[1] = 1'b1;
        #1;
        chk("w3_rst_valid", 32'(rsp_valid_a[1]), 32'd0);
        chk("w3_rst_ready", 32'(req_ready_a[1]), 32'd1);
        @(negedge clk);
        rst_a[1] = 1'b0;
        xact(1, 0, 32'h4020, 32'h0, 3'd2, 2'd0, 0, rd, er, lat);
        chk("w3_dropped_store", rd, 32'h0);

        // Randomized phase on the wait=1 instance.
        for (int w = 0; w < 128; w += 4) run0(1, 32'(w), $urandom, 3'd0, 2'd2, 0, rd, er);
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = 32'h1000 + $urandom_range(0, 32'hFFF);
            else if (r == 1) a = $urandom;
            else             a = $urandom_range(0, 127);
            run0(1'($urandom_range(0, 1)), a, $urandom,
                 ($urandom_range(0, 7) < 6) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
